// File: rtl/window3x3_pkg.sv
// rtl/window3x3_pkg.sv - shared pixel width, frame defaults and state encoding for the window pipeline
package window3x3_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One window column: [2] = row r-2 (top), [1] = row r-1, [0] = row r (bottom)
  typedef logic [3*PIX_W-1:0] column_t;
  typedef logic [9*PIX_W-1:0] window_t;

  function automatic logic [PIX_W-1:0] col_byte(input column_t c, input int idx);
    return c[idx*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/linebuf_ram.sv
// rtl/linebuf_ram.sv - simple dual-port line buffer, synchronous read, read-before-write
module linebuf_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Non-blocking update gives the old word on a same-address read and write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - raster 3x3 neighbourhood generator feeding the Sobel direction stage
module window3x3_gen
  import window3x3_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sof,
  input  logic             din_valid,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic [PIX_W-1:0] p9,
  output logic             dout_valid,
  output logic             dout_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_win_q, s1_win_d;
  logic            s1_eof_q, s1_eof_d;
  logic [CW-1:0]   s1_col_q, s1_col_d;
  logic [PIX_W-1:0] s1_din_q, s1_din_d;

  logic            s2_win_q, s2_win_d;
  logic            s2_eof_q, s2_eof_d;
  column_t         cl0_q, cl0_d, cl1_q, cl1_d, cl2_q, cl2_d;

  window_t         win_q, win_d;
  logic            dout_valid_q, dout_valid_d;
  logic            dout_eof_q, dout_eof_d;

  logic            accept;
  logic            at_last;
  logic [CW-1:0]   pos_c;
  logic [RW-1:0]   pos_r;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  // LB0 holds row r-1; its displaced word cascades into LB1 one cycle later
  linebuf_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .waddr (pos_c),
    .wdata (din),
    .re    (accept),
    .raddr (pos_c),
    .rdata (lb0_rd)
  );

  linebuf_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (s1_valid_q),
    .waddr (s1_col_q),
    .wdata (lb0_rd),
    .re    (accept),
    .raddr (pos_c),
    .rdata (lb1_rd)
  );

  always_comb begin
    accept  = din_valid && ((state_q != ST_DONE) || sof);
    pos_c   = sof ? '0 : col_q;
    pos_r   = sof ? '0 : row_q;
    at_last = (pos_c == COL_LAST) && (pos_r == ROW_LAST);

    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (accept) begin
      if (at_last) begin
        state_d = ST_DONE;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = ST_RUN;
        if (pos_c == COL_LAST) begin
          col_d = '0;
          row_d = pos_r + RW'(1);
        end else begin
          col_d = pos_c + CW'(1);
          row_d = pos_r;
        end
      end
    end

    s1_valid_d = accept;
    s1_win_d   = accept && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
    s1_eof_d   = accept && at_last;
    s1_col_d   = accept ? pos_c : s1_col_q;
    s1_din_d   = accept ? din : s1_din_q;

    s2_win_d = s1_win_q;
    s2_eof_d = s1_eof_q;
    cl0_d    = cl0_q;
    cl1_d    = cl1_q;
    cl2_d    = cl2_q;
    if (s1_valid_q) begin
      cl0_d = cl1_q;
      cl1_d = cl2_q;
      cl2_d = {lb1_rd, lb0_rd, s1_din_q};
    end

    win_d = win_q;
    if (s2_win_q) begin
      win_d = {col_byte(cl0_q, 2), col_byte(cl1_q, 2), col_byte(cl2_q, 2),
               col_byte(cl0_q, 1), col_byte(cl1_q, 1), col_byte(cl2_q, 1),
               col_byte(cl0_q, 0), col_byte(cl1_q, 0), col_byte(cl2_q, 0)};
    end
    dout_valid_d = s2_win_q;
    dout_eof_d   = s2_eof_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_win_q     <= 1'b0;
      s1_eof_q     <= 1'b0;
      s1_col_q     <= '0;
      s1_din_q     <= '0;
      s2_win_q     <= 1'b0;
      s2_eof_q     <= 1'b0;
      cl0_q        <= '0;
      cl1_q        <= '0;
      cl2_q        <= '0;
      win_q        <= '0;
      dout_valid_q <= 1'b0;
      dout_eof_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_win_q     <= s1_win_d;
      s1_eof_q     <= s1_eof_d;
      s1_col_q     <= s1_col_d;
      s1_din_q     <= s1_din_d;
      s2_win_q     <= s2_win_d;
      s2_eof_q     <= s2_eof_d;
      cl0_q        <= cl0_d;
      cl1_q        <= cl1_d;
      cl2_q        <= cl2_d;
      win_q        <= win_d;
      dout_valid_q <= dout_valid_d;
      dout_eof_q   <= dout_eof_d;
    end
  end

  assign {p1, p2, p3, p4, p5, p6, p7, p8, p9} = win_q;
  assign dout_valid = dout_valid_q;
  assign dout_eof   = dout_eof_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// tb/tb_window3x3_gen.sv - directed bench for window3x3_gen on a 4x4 frame
module tb_window3x3_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk;
  logic       rst;
  logic       sof;
  logic       din_valid;
  logic [7:0] din;
  logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic       dout_valid;
  logic       dout_eof;

  window3x3_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .din_valid  (din_valid),
    .din        (din),
    .p1         (p1),
    .p2         (p2),
    .p3         (p3),
    .p4         (p4),
    .p5         (p5),
    .p6         (p6),
    .p7         (p7),
    .p8         (p8),
    .p9         (p9),
    .dout_valid (dout_valid),
    .dout_eof   (dout_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] p;
    logic        eof;
    int          due;
  } win_t;

  win_t        exp_q[$];
  logic [71:0] win_log [32];
  logic [7:0]  img [H][W];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_win = 0;
  int          edge_cnt = 0;
  int          m_state = 0;
  int          m_r = 0;
  int          m_c = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_r     = 0;
    m_c     = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic v, input logic s, input logic [7:0] d);
    int   r, c;
    win_t w;
    if (!v) return;
    if (m_state == 2 && !s) return;
    r = s ? 0 : m_r;
    c = s ? 0 : m_c;
    img[r][c] = d;
    if (r >= 2 && c >= 2) begin
      w.p   = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
               img[r-1][c-2], img[r-1][c-1], img[r-1][c],
               img[r][c-2],   img[r][c-1],   img[r][c]};
      w.eof = (r == H-1) && (c == W-1);
      w.due = edge_cnt + 2;
      exp_q.push_back(w);
    end
    if (r == H-1 && c == W-1) begin
      m_state = 2;
      m_r     = 0;
      m_c     = 0;
    end else begin
      m_state = 1;
      if (c == W-1) begin
        m_c = 0;
        m_r = r + 1;
      end else begin
        m_c = c + 1;
        m_r = r;
      end
    end
  endtask

  task automatic monitor();
    win_t        w;
    logic [71:0] got;
    got = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    if (dout_valid) begin
      if (n_win < 32) win_log[n_win] = got;
      n_win++;
      if (exp_q.size() == 0) begin
        check("unexpected_win", 72'd1, 72'd0);
      end else begin
        w = exp_q.pop_front();
        check("win_data", got, w.p);
        check("win_edge", 72'(edge_cnt), 72'(w.due));
        check("win_eof", 72'(dout_eof), 72'(w.eof));
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      check("win_missing", 72'd0, 72'd1);
      w = exp_q.pop_front();
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    din_valid = v;
    sof       = s;
    din       = d;
    @(posedge clk);
    edge_cnt++;
    if (rst) model_accept(v, s, d);
    #1;
    monitor();
    din_valid = 1'b0;
    sof       = 1'b0;
    din       = 8'h00;
  endtask

  task automatic send_frame(input int base, input logic with_sof, input int max_gap);
    for (int k = 0; k < W*H; k++) begin
      repeat ($urandom_range(0, max_gap)) step(1'b0, 1'b0, 8'h00);
      step(1'b1, with_sof && (k == 0), 8'(base + k));
    end
  endtask

  task automatic drain(input string tag);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check(tag, 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    rst       = 1'b0;
    sof       = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    model_reset();
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    check("reset_p", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'd0);
    check("reset_valid", 72'(dout_valid), 72'd0);
    check("reset_eof", 72'(dout_eof), 72'd0);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // continuous frame 1..16
    n_win = 0;
    send_frame(1, 1'b1, 0);
    drain("drain_cont");
    check("cont_count", 72'(n_win), 72'd4);
    check("cont_first", win_log[0], 72'h01_02_03_05_06_07_09_0a_0b);
    check("cont_last", win_log[3], 72'h06_07_08_0a_0b_0c_0e_0f_10);

    // same frame with idle gaps
    n_win = 0;
    send_frame(1, 1'b1, 3);
    drain("drain_gaps");
    check("gaps_count", 72'(n_win), 72'd4);
    check("gaps_first", win_log[0], 72'h01_02_03_05_06_07_09_0a_0b);
    check("gaps_last", win_log[3], 72'h06_07_08_0a_0b_0c_0e_0f_10);

    // back-to-back frames
    n_win = 0;
    send_frame(1, 1'b1, 0);
    send_frame(101, 1'b1, 0);
    drain("drain_b2b");
    check("b2b_count", 72'(n_win), 72'd8);
    check("b2b_f2_first", win_log[4], 72'h65_66_67_69_6a_6b_6d_6e_6f);

    // trailing pixels without sof are ignored, next frame is clean
    n_win = 0;
    send_frame(1, 1'b1, 0);
    drain("drain_f1");
    n_win = 0;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'(70 + k));
    drain("drain_extra");
    check("extra_count", 72'(n_win), 72'd0);
    n_win = 0;
    send_frame(21, 1'b1, 0);
    drain("drain_after_extra");
    check("after_extra_count", 72'(n_win), 72'd4);
    check("after_extra_first", win_log[0], 72'h15_16_17_19_1a_1b_1d_1e_1f);

    // early sof on the 7th pixel restarts the frame
    n_win = 0;
    for (int k = 0; k < 6; k++) step(1'b1, k == 0, 8'(1 + k));
    send_frame(201, 1'b1, 0);
    drain("drain_early");
    check("early_count", 72'(n_win), 72'd4);
    check("early_first", win_log[0], 72'hc9_ca_cb_cd_ce_cf_d1_d2_d3);

    // reset mid-frame after pixel 10
    n_win = 0;
    for (int k = 0; k < 10; k++) step(1'b1, k == 0, 8'(1 + k));
    rst = 1'b0;
    #1;
    check("midrst_p", {p1, p2, p3, p4, p5, p6, p7, p8, p9}, 72'd0);
    check("midrst_valid", 72'(dout_valid), 72'd0);
    check("midrst_eof", 72'(dout_eof), 72'd0);
    model_reset();
    step(1'b1, 1'b0, 8'd11);
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    send_frame(51, 1'b0, 0);
    drain("drain_midrst");
    check("midrst_count", 72'(n_win), 72'd4);
    check("midrst_first", win_log[0], 72'h33_34_35_37_38_39_3b_3c_3d);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
